// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC round-robin scheduler.
package cordic_pkg;

  localparam int DEF_W  = 16;
  localparam int DEF_RW = 32;

  localparam logic [3:0] FUNC_ARCTAN = 4'd0;
  localparam logic [3:0] FUNC_MAG    = 4'd1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  // Only arctan and magnitude are implemented by the engine.
  function automatic logic func_legal(input logic [3:0] f);
    return (f == FUNC_ARCTAN) || (f == FUNC_MAG);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found;
  int   k;

  // Scan from ptr upward with wrap; the first valid requester wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned (which would infer a latch); blocking '=' is correct here.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one CORDIC vectoring engine among N_REQ requesters. A round-robin
// grant latches the winner's operands, the engine is started with a one-cycle
// pulse, its done is awaited under a watchdog, and the result (or an error) is
// returned to the winner over a valid/ready response channel.
module cordic_rr_scheduler
  import cordic_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int W           = DEF_W,
  parameter int RW          = DEF_RW,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  input  logic [N_REQ*4-1:0] req_func,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [RW-1:0]      rsp_data,
  output logic               rsp_err,
  output logic               eng_st,
  output logic [W-1:0]       eng_x,
  output logic [W-1:0]       eng_y,
  output logic [3:0]         eng_func,
  input  logic               eng_done,
  input  logic [RW-1:0]      eng_result
);

  localparam int IW  = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  state_t           state, state_nx;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    gnt_idx;
  logic [WDW-1:0]   watchdog;
  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic [W-1:0]     sel_x, sel_y;
  logic [3:0]       sel_func;
  logic             accept;
  logic             timeout;
  logic             rsp_hs;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign sel_x    = req_x[int'(arb_idx)*W +: W];
  assign sel_y    = req_y[int'(arb_idx)*W +: W];
  assign sel_func = req_func[int'(arb_idx)*4 +: 4];
  assign accept   = (state == IDLE) && (|req_valid);
  // Fires on the TIMEOUT_CYC-th cycle spent in WAIT; a done in that cycle wins.
  assign timeout  = (watchdog == WDW'(TIMEOUT_CYC - 1));
  assign rsp_hs   = (state == RESP) && rsp_ready[gnt_idx];

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = '0;
    eng_st    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready = arb_grant;
          state_nx  = func_legal(sel_func) ? LAUNCH : RESP;
        end
      end
      LAUNCH: begin
        eng_st   = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (eng_done || timeout) state_nx = RESP;
      end
      RESP: begin
        rsp_valid[gnt_idx] = 1'b1;
        if (rsp_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Operand latches, watchdog, response register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all of these drive outputs or steer arbitration, so each is reset;
    // there is no memory array here that could be left unreset.
    if (!rst_n) begin
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      watchdog <= '0;
      eng_x    <= '0;
      eng_y    <= '0;
      eng_func <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            gnt_idx  <= arb_idx;
            eng_x    <= sel_x;
            eng_y    <= sel_y;
            eng_func <= sel_func;
            rsp_err  <= !func_legal(sel_func);
            rsp_data <= '0;
          end
        end
        LAUNCH: begin
          watchdog <= '0;
        end
        WAIT: begin
          if (watchdog != '1) watchdog <= watchdog + 1'b1;
          if (eng_done) begin
            rsp_data <= eng_result;
            rsp_err  <= 1'b0;
          end else if (timeout) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_hs) rr_ptr <= wrap_inc(gnt_idx);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Self-checking bench for cordic_rr_scheduler: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a round-robin reference model.
module tb_cordic_rr_scheduler;
  import cordic_pkg::*;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int RW = 32;
  localparam int TO = 64;

  logic             clk, rst_n;
  logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0]   req_x, req_y;
  logic [N*4-1:0]   req_func;
  logic [RW-1:0]    rsp_data, eng_result;
  logic             rsp_err, eng_st, eng_done;
  logic [W-1:0]     eng_x, eng_y;
  logic [3:0]       eng_func;

  cordic_rr_scheduler #(.N_REQ(N), .W(W), .RW(RW), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_func   (req_func),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .eng_st     (eng_st),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_func   (eng_func),
    .eng_done   (eng_done),
    .eng_result (eng_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Engine model state: eng_dly == 0 means the engine never answers.
  bit eng_pend = 0;
  bit eng_rand = 0;
  int eng_cnt  = 0;
  int eng_dly  = 0;

  typedef struct {
    int          idx;
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  f;
    int          dly;
    logic [31:0] data;
    logic        err;
    int          lat;   // cycles from accept to first rsp_valid
    int          nst;   // engine start pulses expected
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in engine result: arctan -> x^y^3244, magnitude -> {ABCD, x+y}.
  function automatic logic [31:0] model_result(input logic [15:0] x, input logic [15:0] y,
                                               input logic [3:0] f);
    if (f == FUNC_MAG) return {16'hABCD, 16'(x + y)};
    return {16'h0000, x ^ y ^ 16'h3244};
  endfunction

  task automatic set_req(input int k, input logic [15:0] x, input logic [15:0] y,
                         input logic [3:0] f);
    req_x[k*W +: W]  = x;
    req_y[k*W +: W]  = y;
    req_func[k*4 +: 4] = f;
  endtask

  // Advance one clock and run the engine model just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    eng_done   = 1'b0;
    eng_result = '0;
    if (eng_pend) begin
      eng_cnt++;
      if (eng_cnt == eng_dly) begin
        eng_done   = 1'b1;
        eng_result = model_result(eng_x, eng_y, eng_func);
        eng_pend   = 0;
      end
    end
    if (eng_st) begin
      eng_pend = 1;
      eng_cnt  = 0;
      if (eng_rand) eng_dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 30));
    end
  endtask

  task automatic run_single(input vec_t v);
    logic [N-1:0] oh;
    int acc, st_seen;
    bit got;
    oh = 4'b0001 << v.idx;
    eng_rand  = 0;
    eng_dly   = v.dly;
    rsp_ready = '0;
    set_req(v.idx, v.x, v.y, v.f);
    req_valid = oh;
    #1;
    check("accept_ready", req_ready, oh);
    acc = cyc;
    tick();
    req_valid = '0;
    set_req(v.idx, ~v.x, ~v.y, 4'hE);
    #1;
    st_seen = int'(eng_st);
    got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      if (rsp_valid != '0) got = 1;
      else begin
        tick();
        #1;
        st_seen += int'(eng_st);
      end
    end
    check("rsp_arrived", got, 1);
    check("rsp_latency", cyc - acc, v.lat);
    check("eng_starts", st_seen, v.nst);
    check("rsp_valid", rsp_valid, oh);
    check("rsp_data", rsp_data, v.data);
    check("rsp_err", rsp_err, v.err);
    rsp_ready = ~oh;
    tick();
    #1;
    check("rsp_hold_valid", rsp_valid, oh);
    check("rsp_hold_data", rsp_data, v.data);
    rsp_ready = oh;
    tick();
    rsp_ready = '0;
    #1;
    check("rsp_released", rsp_valid, '0);
  endtask

  task automatic drain(input int n);
    rsp_ready = '1;
    for (int i = 0; i < n; i++) tick();
    rsp_ready = '0;
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int order[5];
    int n, nst, overlap, hs_c, viol, eg, k2, n_done, m_ptr, m_g;
    bit inflight, got, m_busy, m_seen;
    logic [N-1:0] drop;
    logic [15:0] m_x, m_y;
    logic [3:0]  m_f, f;
    logic [31:0] exp_d;
    logic        exp_e;
    vec_t v6;

    //               idx x         y         f      dly data            err lat nst
    tbl[0] = '{0, 16'h0100, 16'h0100, 4'd0,  20, 32'h0000_3244, 1'b0, 22, 1};
    tbl[1] = '{1, 16'h1234, 16'h00FF, 4'd1,   5, 32'hABCD_1333, 1'b0,  7, 1};
    tbl[2] = '{2, 16'h0000, 16'h0000, 4'd5,  20, 32'h0000_0000, 1'b1,  1, 0};
    tbl[3] = '{3, 16'hAAAA, 16'h5555, 4'd0,   1, 32'h0000_CDBB, 1'b0,  3, 1};
    tbl[4] = '{1, 16'hFFFF, 16'h0001, 4'd1,  64, 32'hABCD_0000, 1'b0, 66, 1};
    tbl[5] = '{0, 16'h1111, 16'h2222, 4'd0,  65, 32'h0000_0000, 1'b1, 66, 1};
    tbl[6] = '{2, 16'h7777, 16'h0000, 4'd15,  3, 32'h0000_0000, 1'b1,  1, 0};
    tbl[7] = '{3, 16'h8000, 16'h8000, 4'd1,   0, 32'h0000_0000, 1'b1, 66, 1};
    order  = '{0, 1, 2, 3, 0};

    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_x = '0; req_y = '0; req_func = '0;
    eng_done = 1'b0; eng_result = '0;
    tick(); tick();
    check("reset_ctrl", {req_ready, rsp_valid, rsp_err, eng_st, eng_func}, '0);
    check("reset_data", {rsp_data, eng_x, eng_y}, '0);
    rst_n = 1'b1;
    tick();
    #1;
    check("idle_no_grant", {req_ready, eng_st, rsp_valid}, '0);

    // Directed vectors: single ops, illegal funcs, done-vs-timeout boundary, timeout.
    for (int i = 0; i < 8; i++) run_single(tbl[i]);

    // Stray done after the timeout, in IDLE: must be ignored.
    eng_done = 1'b1;
    eng_result = '1;
    tick();
    #1;
    check("stray_done_ignored", {rsp_valid, eng_st}, '0);

    // All four valid from pointer 0: grants 0,1,2,3,0 with no engine overlap.
    eng_rand = 0; eng_dly = 3; rsp_ready = '1;
    for (int k = 0; k < N; k++) set_req(k, 16'(k * 16'h0111), 16'(k), 4'(k % 2));
    req_valid = '1;
    n = 0; nst = 0; overlap = 0; hs_c = -1; inflight = 0;
    for (int c = 0; c < 300 && n < 5; c++) begin
      #1;
      if (eng_st) begin
        nst++;
        if (inflight) overlap++;
        inflight = 1;
      end
      if (req_ready != '0) begin
        check("rr_grant", req_ready, 4'b0001 << order[n]);
        if (hs_c >= 0) check("regrant_gap", cyc - hs_c, 1);
        n++;
      end
      if ((rsp_valid & rsp_ready) != '0) begin
        inflight = 0;
        hs_c = cyc;
      end
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (eng_st) begin
        nst++;
        if (inflight) overlap++;
        inflight = 1;
      end
      if ((rsp_valid & rsp_ready) != '0) inflight = 0;
      tick();
    end
    rsp_ready = '0;
    check("rr_n_grants", n, 5);
    check("rr_starts", nst, 5);
    check("rr_no_overlap", overlap, 0);

    // Response stall: pointer is now 1; requester 2 alone wins, then others wait.
    eng_dly = 4;
    set_req(2, 16'h0102, 16'h0304, FUNC_MAG);
    req_valid = 4'b0100;
    #1;
    check("stall_accept", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1011;
    set_req(0, 16'h0001, 16'h0002, 4'd0);
    set_req(1, 16'h0003, 16'h0004, 4'd0);
    set_req(3, 16'h0005, 16'h0006, 4'd1);
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      if (rsp_valid != '0) got = 1;
      else tick();
    end
    check("stall_rsp_arrived", got, 1);
    check("stall_rsp_data", rsp_data, 32'hABCD_0406);
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      if (rsp_valid != 4'b0100 || rsp_data != 32'hABCD_0406 || rsp_err || req_ready != '0 || eng_st)
        viol++;
    end
    check("stall_stable", viol, 0);
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    #1;
    check("grant_after_hs", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    drain(20);

    // Reset in WAIT: pointer moved to 2 first, then reset mid-operation.
    v6 = '{1, 16'h0005, 16'h0006, 4'd1, 2, 32'hABCD_000B, 1'b0, 4, 1};
    run_single(v6);
    eng_dly = 20;
    set_req(2, 16'h4321, 16'h1111, 4'd0);
    req_valid = 4'b0100;
    #1;
    check("wait_accept", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    repeat (5) tick();
    #1;
    check("wait_no_rsp", rsp_valid, '0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {req_ready, rsp_valid, rsp_err, eng_st, eng_func}, '0);
    check("rst_mid_data", {rsp_data, eng_x, eng_y}, '0);
    eng_pend = 0;
    tick();
    rst_n = 1'b1;
    eng_done = 1'b1;
    eng_result = '1;
    tick();
    #1;
    check("late_done_ignored", {rsp_valid, eng_st}, '0);
    req_valid = '1;
    eng_dly = 3;
    #1;
    check("post_rst_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    drain(20);

    // Randomized traffic against the round-robin reference model.
    eng_rand = 1;
    m_busy = 0; m_ptr = 1; n_done = 0; m_g = 0; m_seen = 0;
    m_x = '0; m_y = '0; m_f = '0;
    for (int c = 0; c < 20000 && n_done < 60; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
          f = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
          set_req(k, 16'($urandom), 16'($urandom), f);
          req_valid[k] = 1'b1;
        end
      end
      rsp_ready = N'($urandom);
      #1;
      drop = '0;
      if (!m_busy) begin
        check("rnd_rsp_idle", rsp_valid, '0);
        if (req_valid != '0) begin
          eg = -1;
          for (int i = 0; i < N; i++) begin
            k2 = (m_ptr + i) % N;
            if (eg < 0 && req_valid[k2]) eg = k2;
          end
          check("rnd_grant", req_ready, 4'b0001 << eg);
          m_busy = 1; m_g = eg; m_seen = 0;
          m_x = req_x[eg*W +: W];
          m_y = req_y[eg*W +: W];
          m_f = req_func[eg*4 +: 4];
          drop = 4'b0001 << eg;
        end else begin
          check("rnd_no_grant", req_ready, '0);
        end
      end else begin
        check("rnd_busy_no_grant", req_ready, '0);
        if (rsp_valid != '0) begin
          if (!m_seen) begin
            if (m_f > 4'd1 || eng_dly == 0) begin
              exp_d = '0;
              exp_e = 1'b1;
            end else begin
              exp_d = model_result(m_x, m_y, m_f);
              exp_e = 1'b0;
            end
            check("rnd_rsp_valid", rsp_valid, 4'b0001 << m_g);
            check("rnd_rsp_data", rsp_data, exp_d);
            check("rnd_rsp_err", rsp_err, exp_e);
            m_seen = 1;
          end
          if (rsp_ready[m_g]) begin
            m_busy = 0;
            m_ptr = (m_g + 1) % N;
            n_done++;
          end
        end
      end
      tick();
      req_valid = req_valid & ~drop;
    end
    check("rnd_done", n_done, 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
